// File: rtl/game_pkg.sv
// Shared types and helpers for the game flow controller.
//   game_state_e     : top-level game sequencer states
//   DEFAULT_SCORE_W  : default score register width
//   LEVEL_MAX        : level counter saturation value
//   rise()           : rising-edge detect from a registered sample and its previous value
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAYING,
    HIT,
    CLEARED,
    GAME_OVER
  } game_state_e;

  localparam int unsigned DEFAULT_SCORE_W = 16;
  localparam logic [3:0]  LEVEL_MAX       = 4'd15;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Bundle between the game flow controller and its surroundings.
//   master : the controller (consumes key/collision/visibility, drives status)
//   slave  : the environment (ball controller, input logic, display)
// Signals: startKey, frameTick, col_rope_ball, col_player_ball, the three ball
// visibility flags in; unitActive, lives, score, level, levelWon, gameOver,
// playerBlink out of the controller.
interface game_flow_controller_if #(
  parameter int unsigned SCORE_W = game_pkg::DEFAULT_SCORE_W
);
  logic               startKey;
  logic               frameTick;
  logic               col_rope_ball;
  logic               col_player_ball;
  logic               hugeBallVisible;
  logic               bigBall1Visible;
  logic               bigBall2Visible;
  logic               unitActive;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [3:0]         level;
  logic               levelWon;
  logic               gameOver;
  logic               playerBlink;

  modport master (
    input  startKey, frameTick, col_rope_ball, col_player_ball,
           hugeBallVisible, bigBall1Visible, bigBall2Visible,
    output unitActive, lives, score, level, levelWon, gameOver, playerBlink
  );

  modport slave (
    output startKey, frameTick, col_rope_ball, col_player_ball,
           hugeBallVisible, bigBall1Visible, bigBall2Visible,
    input  unitActive, lives, score, level, levelWon, gameOver, playerBlink
  );
endinterface

// File: rtl/frame_timer.sv
// Frame-rate down-counter.
//   clk, resetN : clock, asynchronous active-low reset
//   i_load      : load i_load_val (wins over i_tick)
//   i_tick      : decrement enable (one pulse per video frame), stops at 0
//   o_count     : current count
//   o_done      : high while count is 0
module frame_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_tick,
  output logic [Width-1:0] o_count,
  output logic             o_done
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == '0);

endmodule

// File: rtl/game_flow_controller.sv
// Game-level sequencer: lives, score, level, hit recovery, level clear and game over.
//   clk, resetN : clock, asynchronous active-low reset
//   bus         : game_flow_controller_if.master (inputs from keys / ball controller,
//                 registered status outputs)
// Optional feature macro GAME_CTRL_INVULN_EN: post-hit invulnerability window with a
// blinking indicator; when undefined, playerBlink is tied low.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned SCORE_W       = DEFAULT_SCORE_W,
  parameter int unsigned POP_POINTS    = 10,
  parameter int unsigned CLEAR_BONUS   = 100,
  parameter int unsigned HIT_FRAMES    = 60,
  parameter int unsigned CLEAR_FRAMES  = 90,
  parameter int unsigned INVULN_FRAMES = 120
) (
  input logic                    clk,
  input logic                    resetN,
  game_flow_controller_if.master bus
);

  localparam int unsigned TmrMax = (HIT_FRAMES > CLEAR_FRAMES) ? HIT_FRAMES : CLEAR_FRAMES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 2);

  localparam logic [TmrW-1:0]  HitLoad   = TmrW'(HIT_FRAMES);
  localparam logic [TmrW-1:0]  ClearLoad = TmrW'(CLEAR_FRAMES);
  localparam logic [SCORE_W:0] PopAdd    = (SCORE_W + 1)'(POP_POINTS);
  localparam logic [SCORE_W:0] BonusAdd  = (SCORE_W + 1)'(CLEAR_BONUS);

  // Add with an extra carry bit; a carry out pins the score at all-ones.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W:0]   b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + b;
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  game_state_e      r_state, w_state_next;
  logic [2:0]       r_lives, w_lives_next;
  logic [SCORE_W-1:0] r_score, w_score_next;
  logic [3:0]       r_level, w_level_next;
  logic             r_armed, w_armed_next;
  logic             r_unit_active, r_level_won, r_game_over, r_blink;
  logic             r_start, r_start_prev, r_rope, r_rope_prev, r_player, r_player_prev;

  logic             w_start_evt, w_rope_evt, w_player_evt, w_any_vis;
  logic             w_tmr_load, w_tmr_done;
  logic [TmrW-1:0]  w_tmr_val, w_tmr_count_unused;
  logic             w_invuln, w_blink_next;

  // Inputs are sampled first, so each event appears one cycle after its input rises.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_start       <= 1'b0;
      r_start_prev  <= 1'b0;
      r_rope        <= 1'b0;
      r_rope_prev   <= 1'b0;
      r_player      <= 1'b0;
      r_player_prev <= 1'b0;
    end else begin
      r_start       <= bus.startKey;
      r_start_prev  <= r_start;
      r_rope        <= bus.col_rope_ball;
      r_rope_prev   <= r_rope;
      r_player      <= bus.col_player_ball;
      r_player_prev <= r_player;
    end
  end

  assign w_start_evt  = rise(r_start, r_start_prev);
  assign w_rope_evt   = rise(r_rope, r_rope_prev);
  assign w_player_evt = rise(r_player, r_player_prev);
  assign w_any_vis    = bus.hugeBallVisible | bus.bigBall1Visible | bus.bigBall2Visible;

  frame_timer #(.Width(TmrW)) u_state_timer (
    .clk        (clk),
    .resetN     (resetN),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_tick     (bus.frameTick),
    .o_count    (w_tmr_count_unused),
    .o_done     (w_tmr_done)
  );

`ifdef GAME_CTRL_INVULN_EN
  localparam int unsigned InvRawW = $clog2(INVULN_FRAMES + 2);
  localparam int unsigned InvW    = (InvRawW < 4) ? 4 : InvRawW;

  logic            w_inv_load, w_inv_done, w_inv_unused;
  logic [InvW-1:0] w_inv_count;

  // Window opens on every redeploy after a hit.
  assign w_inv_load = (r_state == HIT) && (w_state_next == PLAYING);

  frame_timer #(.Width(InvW)) u_invuln_timer (
    .clk        (clk),
    .resetN     (resetN),
    .i_load     (w_inv_load),
    .i_load_val (InvW'(INVULN_FRAMES)),
    .i_tick     (bus.frameTick),
    .o_count    (w_inv_count),
    .o_done     (w_inv_done)
  );

  assign w_invuln     = ~w_inv_done;
  // Bit 3 of a frame down-counter flips every 8 frames.
  assign w_blink_next = w_invuln & w_inv_count[3];
  assign w_inv_unused = ^w_inv_count;
`else
  logic w_invuln_cfg_unused;
  assign w_invuln            = 1'b0;
  assign w_blink_next        = 1'b0;
  assign w_invuln_cfg_unused = (INVULN_FRAMES != 0);
`endif

  always_comb begin
    w_state_next = r_state;
    w_lives_next = r_lives;
    w_score_next = r_score;
    w_level_next = r_level;
    w_armed_next = r_armed;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;

    unique case (r_state)
      IDLE, GAME_OVER: begin
        if (w_start_evt) begin
          w_lives_next = 3'(LIVES_INIT);
          w_score_next = '0;
          w_level_next = 4'd1;
          w_armed_next = 1'b0;
          w_state_next = PLAYING;
        end
      end
      PLAYING: begin
        if (w_any_vis) w_armed_next = 1'b1;
        if (w_rope_evt) w_score_next = sat_add(r_score, PopAdd);
        // A hit takes priority over a simultaneous clear; pop scoring still applies.
        if (w_player_evt && !w_invuln) begin
          if (r_lives == 3'd1) begin
            w_lives_next = 3'd0;
            w_state_next = GAME_OVER;
          end else begin
            w_lives_next = r_lives - 3'd1;
            w_tmr_load   = 1'b1;
            w_tmr_val    = HitLoad;
            w_state_next = HIT;
          end
        end else if (r_armed && !w_any_vis) begin
          w_score_next = sat_add(w_score_next, BonusAdd);
          w_tmr_load   = 1'b1;
          w_tmr_val    = ClearLoad;
          w_state_next = CLEARED;
        end
      end
      HIT: begin
        if (w_tmr_done) begin
          w_armed_next = 1'b0;
          w_state_next = PLAYING;
        end
      end
      CLEARED: begin
        if (w_tmr_done) begin
          if (r_level != LEVEL_MAX) w_level_next = r_level + 4'd1;
          w_armed_next = 1'b0;
          w_state_next = PLAYING;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_lives       <= 3'd0;
      r_score       <= '0;
      r_level       <= 4'd0;
      r_armed       <= 1'b0;
      r_unit_active <= 1'b0;
      r_level_won   <= 1'b0;
      r_game_over   <= 1'b0;
      r_blink       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_lives       <= w_lives_next;
      r_score       <= w_score_next;
      r_level       <= w_level_next;
      r_armed       <= w_armed_next;
      r_unit_active <= (w_state_next == PLAYING);
      r_level_won   <= (w_state_next == CLEARED);
      r_game_over   <= (w_state_next == GAME_OVER);
      r_blink       <= w_blink_next;
    end
  end

  assign bus.unitActive  = r_unit_active;
  assign bus.lives       = r_lives;
  assign bus.score       = r_score;
  assign bus.level       = r_level;
  assign bus.levelWon    = r_level_won;
  assign bus.gameOver    = r_game_over;
  assign bus.playerBlink = r_blink;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: a per-cycle vector table for start, scoring
// and level clear, then hand-written sequences for timers, hits, priority and reset.
module tb_game_flow_controller;

  logic clk;
  logic resetN;
  int   n_cmp;
  int   n_bad;

  game_flow_controller_if #(.SCORE_W(16)) bus ();

  game_flow_controller dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       rope;
    logic       player;
    logic [2:0] vis;
    logic       unit;
    int         lives;
    int         score;
    int         level;
    logic       won;
  } vec_t;

  vec_t vecs[10];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic u, input int lv, input int sc,
                           input int lev, input logic won, input logic ov);
    check({tag, "/unitActive"}, int'(bus.unitActive), int'(u));
    check({tag, "/lives"}, int'(bus.lives), lv);
    check({tag, "/score"}, int'(bus.score), sc);
    check({tag, "/level"}, int'(bus.level), lev);
    check({tag, "/levelWon"}, int'(bus.levelWon), int'(won));
    check({tag, "/gameOver"}, int'(bus.gameOver), int'(ov));
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frameTick = 1'b1;
      cycle();
      bus.frameTick = 1'b0;
      cycle();
    end
  endtask

  task automatic pulse_player();
    bus.col_player_ball = 1'b1;
    cycle();
    bus.col_player_ball = 1'b0;
    cycle();
  endtask

  // Lets any post-hit invulnerability window expire before the next scripted hit.
  task automatic wait_invuln();
`ifdef GAME_CTRL_INVULN_EN
    frames(121);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //           start rope player vis     unit lives score level won
    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 0, 0,   0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3, 0,   1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3, 0,   1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 3, 0,   1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 3, 10,  1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 3, 10,  1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3, 10,  1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 3, 10,  1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3, 20,  1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3, 120, 1, 1'b1};

    resetN              = 1'b0;
    bus.startKey        = 1'b0;
    bus.frameTick       = 1'b0;
    bus.col_rope_ball   = 1'b0;
    bus.col_player_ball = 1'b0;
    bus.hugeBallVisible = 1'b0;
    bus.bigBall1Visible = 1'b0;
    bus.bigBall2Visible = 1'b0;
    repeat (2) cycle();
    check_all("reset", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("reset/playerBlink", int'(bus.playerBlink), 0);
    resetN = 1'b1;
    cycle();

    for (int i = 0; i < 10; i++) begin
      bus.startKey        = vecs[i].start;
      bus.col_rope_ball   = vecs[i].rope;
      bus.col_player_ball = vecs[i].player;
      bus.hugeBallVisible = vecs[i].vis[2];
      bus.bigBall1Visible = vecs[i].vis[1];
      bus.bigBall2Visible = vecs[i].vis[0];
      cycle();
      check_all($sformatf("vec%0d", i), vecs[i].unit, vecs[i].lives, vecs[i].score,
                vecs[i].level, vecs[i].won, 1'b0);
    end

    // Clear timer: one frame short, then the exit into level 2.
    frames(89);
    check_all("cleared_wait", 1'b0, 3, 120, 1, 1'b1, 1'b0);
    frames(1);
    check_all("level2", 1'b1, 3, 120, 2, 1'b0, 1'b0);

    // All balls invisible right after redeploy must not clear the level.
    repeat (5) cycle();
    check_all("armed_guard", 1'b1, 3, 120, 2, 1'b0, 1'b0);

    bus.hugeBallVisible = 1'b1;
    cycle();
    pulse_player();
    check_all("hit1", 1'b0, 2, 120, 2, 1'b0, 1'b0);
    frames(59);
    check_all("hit1_wait", 1'b0, 2, 120, 2, 1'b0, 1'b0);
    frames(1);
    check_all("redeploy1", 1'b1, 2, 120, 2, 1'b0, 1'b0);

    // Hit, pop and clear condition in one cycle: hit wins, pop scores, no bonus.
    cycle();
    wait_invuln();
    bus.col_player_ball = 1'b1;
    bus.col_rope_ball   = 1'b1;
    cycle();
    bus.col_player_ball = 1'b0;
    bus.col_rope_ball   = 1'b0;
    bus.hugeBallVisible = 1'b0;
    cycle();
    check_all("hit_vs_clear", 1'b0, 1, 130, 2, 1'b0, 1'b0);
    bus.hugeBallVisible = 1'b1;
    frames(60);
    check_all("redeploy2", 1'b1, 1, 130, 2, 1'b0, 1'b0);

    cycle();
    wait_invuln();
    pulse_player();
    check_all("game_over", 1'b0, 0, 130, 2, 1'b0, 1'b1);

    // Collisions are not scored once the game is over.
    bus.col_rope_ball = 1'b1;
    cycle();
    bus.col_rope_ball = 1'b0;
    cycle();
    check_all("over_hold", 1'b0, 0, 130, 2, 1'b0, 1'b1);

    bus.startKey = 1'b1;
    cycle();
    bus.startKey = 1'b0;
    cycle();
    check_all("restart", 1'b1, 3, 0, 1, 1'b0, 1'b0);

    // A rope collision held for 50 cycles scores once.
    bus.col_rope_ball = 1'b1;
    repeat (50) cycle();
    bus.col_rope_ball = 1'b0;
    cycle();
    check_all("rope_hold", 1'b1, 3, 10, 1, 1'b0, 1'b0);
`ifndef GAME_CTRL_INVULN_EN
    check("no_blink", int'(bus.playerBlink), 0);
`else
    pulse_player();
    check_all("inv_hit", 1'b0, 2, 10, 1, 1'b0, 1'b0);
    frames(60);
    frames(10);
    check("inv_blink", int'(bus.playerBlink), 1);
    pulse_player();
    check_all("inv_ignored_early", 1'b1, 2, 10, 1, 1'b0, 1'b0);
    frames(109);
    pulse_player();
    check_all("inv_ignored_f120", 1'b1, 2, 10, 1, 1'b0, 1'b0);
    frames(1);
    pulse_player();
    check_all("inv_counted_f121", 1'b0, 1, 10, 1, 1'b0, 1'b0);
`endif

    // Asynchronous reset between clock edges.
    #3;
    resetN = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("async_reset/playerBlink", int'(bus.playerBlink), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
